// File: rtl/spi_sdo_tx.sv
// spi_sdo_tx: SPI mode-0 slave transmit path; FIFO-fed bytes shifted MSB first on sdo,
// with spiClk and ce oversampled in the clk domain.
module spi_sdo_tx #(
   parameter int DEPTH = 16,
   parameter logic [7:0] FILL = 8'h00
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       spiClk,
   input  logic                       ce,
   output logic                       sdo,
   input  logic [7:0]                 wrData,
   input  logic                       wrValid,
   output logic                       wrReady,
   output logic [$clog2(DEPTH+1)-1:0] fifoCount,
   output logic                       busy,
   output logic                       byteDone,
   output logic                       underrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic {IDLE, SHIFT} stateT;
   stateT state, stateNxt;
   logic [2:0] sckS, ceS;
   logic [1:0] vld;
   logic armed, sclkRise, sclkFall, ceRise, ceFall;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic empty, push, pop, load, fromFifo, fromNxt;
   logic [7:0] shiftReg, shiftNxt;
   logic [3:0] bitCnt, cntNxt;
   assign sclkRise = sckS[1] & ~sckS[2];
   assign sclkFall = ~sckS[1] & sckS[2];
   // armed blocks a ce level already high at reset release from looking like a rising edge
   assign ceRise = armed & ceS[1] & ~ceS[2];
   assign ceFall = ~ceS[1] & ceS[2];
   assign empty = fifoCount == '0;
   assign wrReady = fifoCount != CW'(DEPTH);
   assign push = wrValid & wrReady;
   assign busy = state == SHIFT;
   assign sdo = busy & shiftReg[7];
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         sckS      <= '0;
         ceS       <= '0;
         vld       <= '0;
         armed     <= 1'b0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         state     <= IDLE;
         shiftReg  <= '0;
         bitCnt    <= '0;
         fromFifo  <= 1'b0;
      end else begin
         sckS      <= {sckS[1:0], spiClk};
         ceS       <= {ceS[1:0], ce};
         vld       <= {vld[0], 1'b1};
         armed     <= armed | (vld[1] & ~ceS[1]);
         wrPtr     <= wrPtr + AW'(push);
         rdPtr     <= rdPtr + AW'(pop);
         fifoCount <= fifoCount + CW'(push) - CW'(pop);
         state     <= stateNxt;
         shiftReg  <= shiftNxt;
         bitCnt    <= cntNxt;
         fromFifo  <= fromNxt;
      end
   always_ff @(posedge clk)
      if (push) mem[wrPtr] <= wrData;
   // the head is only popped on the first rising edge, so an unclocked byte survives ceFall
   always_comb begin
      stateNxt = state;
      shiftNxt = shiftReg;
      cntNxt   = bitCnt;
      fromNxt  = fromFifo;
      pop      = 1'b0;
      load     = 1'b0;
      byteDone = 1'b0;
      underrun = 1'b0;
      if (state == IDLE) begin
         if (ceRise) begin
            load     = 1'b1;
            cntNxt   = '0;
            stateNxt = SHIFT;
         end
      end else if (ceFall) begin
         stateNxt = IDLE;
      end else if (sclkRise && bitCnt < 4'd8) begin
         cntNxt   = bitCnt + 4'd1;
         pop      = bitCnt == 4'd0 && fromFifo;
         byteDone = bitCnt == 4'd7;
      end else if (sclkFall) begin
         if (bitCnt == 4'd8) begin
            load   = 1'b1;
            cntNxt = '0;
         end else begin
            shiftNxt = shiftReg << 1;
         end
      end
      if (load) begin
         shiftNxt = empty ? FILL : mem[rdPtr];
         fromNxt  = !empty;
         underrun = empty;
      end
   end
endmodule

// File: tb/tb_spi_sdo_tx.sv
// tb_spi_sdo_tx: directed bench acting as an SPI mode-0 master at clk/8 against spi_sdo_tx.
module tb_spi_sdo_tx;
   logic clk = 1'b0;
   logic nreset, spiClk, ce, sdo, wrValid, wrReady, busy, byteDone, underrun;
   logic [7:0] wrData;
   logic [4:0] fifoCount;
   int checks = 0, failures = 0, underCnt = 0, doneCnt = 0;

   typedef struct {
      logic       doPush;
      logic [7:0] d;
      logic [7:0] expRx;
      int         expUnder;
      int         expCnt;
   } vecT;
   vecT tbl [5];

   spi_sdo_tx #(.DEPTH(16), .FILL(8'h00)) dut (
      .clk(clk), .nreset(nreset), .spiClk(spiClk), .ce(ce), .sdo(sdo),
      .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady), .fifoCount(fifoCount),
      .busy(busy), .byteDone(byteDone), .underrun(underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (underrun) underCnt++;
      if (byteDone) doneCnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wrData  = d;
      wrValid = 1'b1;
      @(negedge clk);
      wrValid = 1'b0;
   endtask

   // one SPI bit: sample sdo, raise spiClk, then lower it (optionally dropping ce with it)
   task automatic bitClk(input logic drop, output logic b);
      b = sdo;
      spiClk = 1'b1;
      repeat (4) @(negedge clk);
      spiClk = 1'b0;
      if (drop) ce = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic xfer(input int n, output logic [31:0] rx);
      logic b;
      rx = '0;
      ce = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         bitClk(i == n - 1, b);
         rx = {rx[30:0], b};
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rx;
      logic b;
      int u0, d0;
      tbl[0] = '{1'b1, 8'h5A, 8'h5A, 0, 0};
      tbl[1] = '{1'b0, 8'h00, 8'h00, 1, 0};
      tbl[2] = '{1'b1, 8'hC3, 8'hC3, 0, 0};
      tbl[3] = '{1'b1, 8'h81, 8'h81, 0, 0};
      tbl[4] = '{1'b0, 8'h00, 8'h00, 1, 0};
      nreset = 1'b0; spiClk = 1'b0; ce = 1'b0; wrValid = 1'b0; wrData = '0;
      repeat (3) @(negedge clk);
      check("rst_count", fifoCount, 0);
      check("rst_wrReady", wrReady, 1);
      check("rst_sdo", sdo, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", {byteDone, underrun}, 0);
      nreset = 1'b1;
      repeat (4) @(negedge clk);

      foreach (tbl[k]) begin
         u0 = underCnt;
         if (tbl[k].doPush) push(tbl[k].d);
         xfer(8, rx);
         check("tbl_rx", rx[7:0], tbl[k].expRx);
         check("tbl_underrun", underCnt - u0, tbl[k].expUnder);
         check("tbl_count", fifoCount, tbl[k].expCnt);
      end

      push(8'hA5); push(8'h3C);
      check("two_count", fifoCount, 2);
      u0 = underCnt; d0 = doneCnt;
      xfer(16, rx);
      check("two_rx", rx[15:0], 16'hA53C);
      check("two_byteDone", doneCnt - d0, 2);
      check("two_underrun", underCnt - u0, 0);
      check("two_count_end", fifoCount, 0);

      push(8'hF0);
      xfer(3, rx);
      check("abort_bits", rx[2:0], 3'b111);
      check("abort_count", fifoCount, 0);
      check("abort_busy", busy, 0);
      check("abort_sdo", sdo, 0);
      u0 = underCnt;
      xfer(8, rx);
      check("abort_next_fill", rx[7:0], 8'h00);
      check("abort_next_underrun", underCnt - u0, 1);

      push(8'h11); push(8'h22);
      xfer(8, rx);
      check("keep_rx", rx[7:0], 8'h11);
      check("keep_count", fifoCount, 1);
      u0 = underCnt;
      xfer(8, rx);
      check("keep_next_rx", rx[7:0], 8'h22);
      check("keep_next_underrun", underCnt - u0, 0);

      for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
      check("full_count", fifoCount, 16);
      check("full_wrReady", wrReady, 0);
      push(8'hEE);
      check("full_ignored", fifoCount, 16);
      wrData = 8'h77;
      wrValid = 1'b1;
      xfer(8, rx);
      wrValid = 1'b0;
      check("full_pop_rx", rx[7:0], 8'h40);
      check("full_refill_count", fifoCount, 16);
      for (int i = 1; i < 16; i++) begin
         xfer(8, rx);
         check("full_order", rx[7:0], 8'h40 + i);
      end
      xfer(8, rx);
      check("full_last", rx[7:0], 8'h77);
      check("full_drained", fifoCount, 0);

      for (int i = 1; i <= 5; i++) push(8'(i));
      ce = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 3; i++) bitClk(1'b0, b);
      nreset = 1'b0;
      #1;
      check("midrst_count", fifoCount, 0);
      check("midrst_sdo", sdo, 0);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      nreset = 1'b1;
      repeat (6) @(negedge clk);
      rx = '0;
      for (int i = 0; i < 8; i++) begin
         bitClk(1'b0, b);
         rx = {rx[30:0], b | busy};
      end
      check("postrst_quiet", rx[7:0], 0);
      check("postrst_busy", busy, 0);
      ce = 1'b0;
      repeat (6) @(negedge clk);
      push(8'h9C);
      xfer(8, rx);
      check("postrst_rx", rx[7:0], 8'h9C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
